// File: rtl/aes_ahb_master.sv
// aes_ahb_master: AHB-Lite initiator that runs AES key-load/encrypt/decrypt
// command sequences (data write, control write, status poll, result read).
module aes_ahb_master #(
    parameter logic [31:0] DATA_ADDR   = 32'h0000_0000,
    parameter logic [31:0] CTRL_ADDR   = 32'h0000_0004,
    parameter logic [31:0] STATUS_ADDR = 32'h0000_0008,
    parameter logic [31:0] RESULT_ADDR = 32'h0000_000C,
    parameter int unsigned RDY_BIT     = 0,
    parameter int unsigned POLL_MAX    = 255
) (
    input  logic         HCLK,
    input  logic         HRESETn,
    input  logic         cmd_valid,
    input  logic [1:0]   cmd_op,
    input  logic [127:0] cmd_data,
    output logic         cmd_ready,
    output logic         rsp_valid,
    input  logic         rsp_ready,
    output logic [127:0] rsp_data,
    output logic         rsp_error,
    output logic [31:0]  HADDR,
    output logic         HWRITE,
    output logic [1:0]   HTRANS,
    output logic [2:0]   HSIZE,
    output logic [2:0]   HBURST,
    output logic [3:0]   HPROT,
    output logic [31:0]  HWDATA,
    input  logic [31:0]  HRDATA,
    input  logic         HREADY,
    input  logic [1:0]   HRESP
);
    localparam int unsigned PCW = $clog2(POLL_MAX + 1);
    localparam int unsigned RIW = 5;
    localparam logic [RIW-1:0] RDY_IDX = RIW'(RDY_BIT);
    localparam logic [PCW-1:0] PCNT_MAX = PCW'(POLL_MAX);
    localparam logic [1:0] TR_IDLE   = 2'b00;
    localparam logic [1:0] TR_NONSEQ = 2'b10;
    localparam logic [1:0] RESP_ERR  = 2'b01;
    localparam logic [1:0] OP_KEY    = 2'b00;
    localparam logic [1:0] OP_ENC    = 2'b01;
    localparam logic [1:0] OP_RSV    = 2'b11;

    typedef enum logic [3:0] {
        S_IDLE, S_WR_A, S_WR_D, S_CT_A, S_CT_D,
        S_PL_A, S_PL_D, S_RD_A, S_RD_D, S_RESP
    } state_t;

    state_t         state, state_n;
    logic [1:0]     op_q, op_n;
    logic [127:0]   data_q, data_n;
    logic [1:0]     wcnt, wcnt_n;
    logic [PCW-1:0] pcnt, pcnt_n, pcnt_inc;
    logic [127:0]   rsp_data_n;
    logic           rsp_error_n;
    logic [31:0]    haddr_n, hwdata_n, ctrl_val;
    logic           hwrite_n, abort;

    assign HSIZE  = 3'b010;
    assign HBURST = 3'b000;
    assign HPROT  = 4'b0011;

    // State, datapath and registered bus/handshake outputs
    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            state     <= S_IDLE;
            op_q      <= 2'b00;
            data_q    <= '0;
            wcnt      <= '0;
            pcnt      <= '0;
            cmd_ready <= 1'b1;
            rsp_valid <= 1'b0;
            rsp_data  <= '0;
            rsp_error <= 1'b0;
            HTRANS    <= TR_IDLE;
            HADDR     <= '0;
            HWRITE    <= 1'b0;
            HWDATA    <= '0;
        end else begin
            state     <= state_n;
            op_q      <= op_n;
            data_q    <= data_n;
            wcnt      <= wcnt_n;
            pcnt      <= pcnt_n;
            cmd_ready <= (state_n == S_IDLE);
            rsp_valid <= (state_n == S_RESP);
            rsp_data  <= rsp_data_n;
            rsp_error <= rsp_error_n;
            HTRANS    <= (state_n == S_WR_A || state_n == S_CT_A ||
                          state_n == S_PL_A || state_n == S_RD_A) ? TR_NONSEQ : TR_IDLE;
            HADDR     <= haddr_n;
            HWRITE    <= hwrite_n;
            HWDATA    <= hwdata_n;
        end
    end

    // Next-state sequencing of the write/poll/read transfer chain
    always_comb begin
        state_n     = state;
        op_n        = op_q;
        data_n      = data_q;
        wcnt_n      = wcnt;
        pcnt_n      = pcnt;
        pcnt_inc    = pcnt + PCW'(1);
        rsp_data_n  = rsp_data;
        rsp_error_n = rsp_error;
        haddr_n     = HADDR;
        hwrite_n    = HWRITE;
        hwdata_n    = HWDATA;
        abort       = 1'b0;
        unique case (op_q)
            OP_KEY:  ctrl_val = 32'd1;
            OP_ENC:  ctrl_val = 32'd2;
            default: ctrl_val = 32'd4;
        endcase

        unique case (state)
            S_IDLE: begin
                if (cmd_valid && cmd_ready) begin
                    op_n        = cmd_op;
                    data_n      = cmd_data;
                    wcnt_n      = '0;
                    pcnt_n      = '0;
                    rsp_data_n  = '0;
                    rsp_error_n = 1'b0;
                    if (cmd_op == OP_RSV) begin
                        state_n     = S_RESP;
                        rsp_error_n = 1'b1;
                    end else begin
                        state_n = S_WR_A;
                    end
                end
            end
            S_WR_A: begin
                if (HREADY) begin
                    state_n  = S_WR_D;
                    hwdata_n = data_q[127:96];
                end
            end
            S_WR_D: begin
                if (HRESP == RESP_ERR) begin
                    abort = 1'b1;
                end else if (HREADY) begin
                    data_n  = {data_q[95:0], 32'h0};
                    wcnt_n  = wcnt + 2'd1;
                    state_n = (wcnt == 2'd3) ? S_CT_A : S_WR_A;
                end
            end
            S_CT_A: begin
                if (HREADY) begin
                    state_n  = S_CT_D;
                    hwdata_n = ctrl_val;
                end
            end
            S_CT_D: begin
                if (HRESP == RESP_ERR) begin
                    abort = 1'b1;
                end else if (HREADY) begin
                    state_n = (op_q == OP_KEY) ? S_RESP : S_PL_A;
                end
            end
            S_PL_A: begin
                if (HREADY) state_n = S_PL_D;
            end
            S_PL_D: begin
                if (HRESP == RESP_ERR) begin
                    abort = 1'b1;
                end else if (HREADY) begin
                    if (HRDATA[RDY_IDX]) begin
                        state_n = S_RD_A;
                    end else begin
                        pcnt_n = pcnt_inc;
                        if (pcnt_inc == PCNT_MAX) begin
                            state_n     = S_RESP;
                            rsp_error_n = 1'b1;
                        end else begin
                            state_n = S_PL_A;
                        end
                    end
                end
            end
            S_RD_A: begin
                if (HREADY) state_n = S_RD_D;
            end
            S_RD_D: begin
                if (HRESP == RESP_ERR) begin
                    abort = 1'b1;
                end else if (HREADY) begin
                    rsp_data_n = {rsp_data[95:0], HRDATA};
                    wcnt_n     = wcnt + 2'd1;
                    state_n    = (wcnt == 2'd3) ? S_RESP : S_RD_A;
                end
            end
            S_RESP: begin
                if (rsp_ready) state_n = S_IDLE;
            end
            default: state_n = S_IDLE;
        endcase

        // Bus error in any data-phase cycle ends the sequence with no further transfers
        if (abort) begin
            state_n     = S_RESP;
            rsp_error_n = 1'b1;
            rsp_data_n  = '0;
        end

        unique case (state_n)
            S_WR_A:  begin haddr_n = DATA_ADDR;   hwrite_n = 1'b1; end
            S_CT_A:  begin haddr_n = CTRL_ADDR;   hwrite_n = 1'b1; end
            S_PL_A:  begin haddr_n = STATUS_ADDR; hwrite_n = 1'b0; end
            S_RD_A:  begin haddr_n = RESULT_ADDR; hwrite_n = 1'b0; end
            default: ;
        endcase
    end
endmodule

// File: tb/tb_aes_ahb_master.sv
// tb_aes_ahb_master: randomized AHB slave plus transaction-level reference model.
module tb_aes_ahb_master;
    localparam int unsigned PMAX = 4;
    localparam logic [31:0] A_DATA = 32'h0;
    localparam logic [31:0] A_CTRL = 32'h4;
    localparam logic [31:0] A_STAT = 32'h8;
    localparam logic [31:0] A_RES  = 32'hC;

    typedef struct packed {
        logic [31:0] addr;
        logic        wr;
        logic [31:0] data;
    } xfer_t;

    logic         HCLK = 1'b0;
    logic         HRESETn = 1'b0;
    logic         cmd_valid = 1'b0;
    logic [1:0]   cmd_op = 2'b00;
    logic [127:0] cmd_data = '0;
    logic         cmd_ready;
    logic         rsp_valid;
    logic         rsp_ready = 1'b0;
    logic [127:0] rsp_data;
    logic         rsp_error;
    logic [31:0]  HADDR;
    logic         HWRITE;
    logic [1:0]   HTRANS;
    logic [2:0]   HSIZE;
    logic [2:0]   HBURST;
    logic [3:0]   HPROT;
    logic [31:0]  HWDATA;
    logic [31:0]  HRDATA = '0;
    logic         HREADY = 1'b1;
    logic [1:0]   HRESP = 2'b00;

    int vectors = 0;
    int miscompares = 0;

    // slave configuration for the current command
    int          cfg_ws = 0;
    int          cfg_rp = 1;
    int          cfg_err = -1;
    logic [31:0] cfg_res [4];

    // slave observation state
    xfer_t       log_q[$];
    int          nonseq_cnt = 0;
    int          stab_viol = 0;
    int          xfer_idx = 0;
    int          poll_idx = 0;
    int          rd_idx = 0;
    bit          in_data = 0;
    bit          first_d = 0;
    bit          err_phase = 0;
    int          wait_left = 0;
    logic [31:0] cur_addr = '0;
    logic        cur_write = 1'b0;
    logic [31:0] cur_wdata = '0;

    // expected results from the model
    xfer_t        exp_q[$];
    logic [127:0] exp_data;
    logic         exp_err;
    int           exp_lat;
    int           exp_nonseq;

    aes_ahb_master #(.POLL_MAX(PMAX)) dut (
        .HCLK(HCLK), .HRESETn(HRESETn),
        .cmd_valid(cmd_valid), .cmd_op(cmd_op), .cmd_data(cmd_data), .cmd_ready(cmd_ready),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data), .rsp_error(rsp_error),
        .HADDR(HADDR), .HWRITE(HWRITE), .HTRANS(HTRANS), .HSIZE(HSIZE), .HBURST(HBURST),
        .HPROT(HPROT), .HWDATA(HWDATA), .HRDATA(HRDATA), .HREADY(HREADY), .HRESP(HRESP)
    );

    always #5 HCLK = ~HCLK;

    // AHB slave: decides HREADY/HRESP/HRDATA for the upcoming edge and logs completed transfers
    initial forever begin
        logic [31:0] tmp;
        xfer_t       t;
        @(negedge HCLK);
        if (!HRESETn) begin
            in_data = 0; err_phase = 0; HREADY = 1'b1; HRESP = 2'b00; HRDATA = '0;
        end else if (err_phase) begin
            HREADY = 1'b1; HRESP = 2'b01; err_phase = 0; in_data = 0;
        end else if (in_data) begin
            if (HTRANS !== 2'b00 || HADDR !== cur_addr || HWRITE !== cur_write) stab_viol++;
            if (first_d) cur_wdata = HWDATA;
            else if (cur_write && HWDATA !== cur_wdata) stab_viol++;
            first_d = 0;
            if (xfer_idx - 1 == cfg_err) begin
                HREADY = 1'b0; HRESP = 2'b01; err_phase = 1;
            end else if (wait_left > 0) begin
                HREADY = 1'b0; HRESP = 2'b00; wait_left--;
            end else begin
                HREADY = 1'b1; HRESP = 2'b00;
                tmp = $urandom();
                if (!cur_write && cur_addr == A_STAT) begin
                    poll_idx++;
                    tmp[0] = (cfg_rp != 0 && poll_idx == cfg_rp);
                end else if (!cur_write && cur_addr == A_RES && rd_idx < 4) begin
                    tmp = cfg_res[rd_idx];
                    rd_idx++;
                end
                HRDATA = tmp;
                t.addr = cur_addr; t.wr = cur_write; t.data = cur_write ? cur_wdata : 32'h0;
                log_q.push_back(t);
                in_data = 0;
            end
        end else if (HTRANS == 2'b10) begin
            nonseq_cnt++;
            cur_addr = HADDR; cur_write = HWRITE;
            in_data = 1; first_d = 1; wait_left = cfg_ws; xfer_idx++;
            HREADY = 1'b1; HRESP = 2'b00;
        end else begin
            HREADY = 1'b1; HRESP = 2'b00;
        end
    end

    function automatic xfer_t mk(input logic [31:0] a, input logic w, input logic [31:0] d);
        xfer_t t;
        t.addr = a; t.wr = w; t.data = d;
        return t;
    endfunction

    // Transaction-level model: bus trace, result, error and latency of one command
    task automatic build_model(input logic [1:0] op, input logic [127:0] d);
        xfer_t nom[$];
        int    n, npoll;
        bit    ready;
        exp_q.delete();
        if (op == 2'b11) begin
            exp_err = 1'b1; exp_data = '0; exp_lat = 1; exp_nonseq = 0;
            return;
        end
        for (int k = 0; k < 4; k++) nom.push_back(mk(A_DATA, 1'b1, d[127-32*k -: 32]));
        nom.push_back(mk(A_CTRL, 1'b1, 32'd1 << op));
        ready = (cfg_rp != 0 && cfg_rp <= int'(PMAX));
        npoll = ready ? cfg_rp : int'(PMAX);
        if (op != 2'b00) begin
            for (int k = 0; k < npoll; k++) nom.push_back(mk(A_STAT, 1'b0, 32'h0));
            if (ready) for (int k = 0; k < 4; k++) nom.push_back(mk(A_RES, 1'b0, 32'h0));
        end
        n = nom.size();
        if (cfg_err >= 0 && cfg_err < n) begin
            for (int i = 0; i < cfg_err; i++) exp_q.push_back(nom[i]);
            exp_err = 1'b1; exp_data = '0;
            exp_lat = 3 + cfg_err * (2 + cfg_ws);
            exp_nonseq = cfg_err + 1;
        end else begin
            exp_q = nom;
            exp_lat = 1 + n * (2 + cfg_ws);
            exp_nonseq = n;
            exp_err = (op != 2'b00) && !ready;
            exp_data = (op != 2'b00 && ready) ? {cfg_res[0], cfg_res[1], cfg_res[2], cfg_res[3]} : '0;
        end
    endtask

    // Configure slave + model, then present one command for a single accept edge
    task automatic start_cmd(input logic [1:0] op, input logic [127:0] d,
                             input int ws, input int rp, input int err);
        cfg_ws = ws; cfg_rp = rp; cfg_err = err;
        for (int i = 0; i < 4; i++) cfg_res[i] = $urandom();
        build_model(op, d);
        log_q.delete();
        nonseq_cnt = 0; stab_viol = 0; xfer_idx = 0; poll_idx = 0; rd_idx = 0;
        @(negedge HCLK);
        vectors++;
        if (cmd_ready !== 1'b1) begin
            miscompares++; $display("FAIL accept_ready got %b want 1", cmd_ready);
        end
        cmd_valid = 1'b1; cmd_op = op; cmd_data = d;
        @(posedge HCLK); #1;
        cmd_valid = 1'b0;
    endtask

    // Wait for the response, compare against the model, then hold/release rsp_ready
    task automatic finish_cmd(input string nm, input int hold, input bit busy);
        int  t;
        bit  seen;
        int  m;
        t = 0; seen = 0;
        for (int k = 1; k <= 4000; k++) begin
            if (rsp_valid === 1'b1) begin t = k; seen = 1; break; end
            @(posedge HCLK); #1;
        end
        vectors++;
        if (!seen) begin
            miscompares++; $display("FAIL %s rsp_timeout no rsp_valid within 4000 cycles", nm);
            return;
        end
        vectors++;
        if (t != exp_lat) begin
            miscompares++; $display("FAIL %s latency got T%0d want T%0d", nm, t, exp_lat);
        end
        vectors++;
        if (rsp_data !== exp_data) begin
            miscompares++; $display("FAIL %s rsp_data got %h want %h", nm, rsp_data, exp_data);
        end
        vectors++;
        if (rsp_error !== exp_err) begin
            miscompares++; $display("FAIL %s rsp_error got %b want %b", nm, rsp_error, exp_err);
        end
        vectors++;
        if (log_q.size() != exp_q.size()) begin
            miscompares++; $display("FAIL %s xfer_count got %0d want %0d", nm, log_q.size(), exp_q.size());
        end
        m = (log_q.size() < exp_q.size()) ? log_q.size() : exp_q.size();
        for (int i = 0; i < m; i++) begin
            vectors++;
            if (log_q[i] !== exp_q[i]) begin
                miscompares++;
                $display("FAIL %s xfer%0d got a=%h w=%b d=%h want a=%h w=%b d=%h", nm, i,
                         log_q[i].addr, log_q[i].wr, log_q[i].data,
                         exp_q[i].addr, exp_q[i].wr, exp_q[i].data);
            end
        end
        vectors++;
        if (nonseq_cnt != exp_nonseq) begin
            miscompares++; $display("FAIL %s nonseq_count got %0d want %0d", nm, nonseq_cnt, exp_nonseq);
        end
        vectors++;
        if (stab_viol != 0) begin
            miscompares++; $display("FAIL %s data_phase_stability got %0d violations want 0", nm, stab_viol);
        end
        for (int h = 0; h < hold; h++) begin
            cmd_valid = busy; cmd_op = 2'($urandom_range(0, 2)); cmd_data = {4{$urandom()}};
            @(posedge HCLK); #1;
            vectors++;
            if (rsp_valid !== 1'b1 || cmd_ready !== 1'b0 || rsp_data !== exp_data) begin
                miscompares++;
                $display("FAIL %s hold%0d got valid=%b ready=%b data=%h want 1 0 %h",
                         nm, h, rsp_valid, cmd_ready, rsp_data, exp_data);
            end
        end
        cmd_valid = 1'b0;
        rsp_ready = 1'b1;
        @(posedge HCLK); #1;
        rsp_ready = 1'b0;
        vectors++;
        if (rsp_valid !== 1'b0 || cmd_ready !== 1'b1) begin
            miscompares++;
            $display("FAIL %s release got valid=%b ready=%b want 0 1", nm, rsp_valid, cmd_ready);
        end
    endtask

    task automatic test_reset;
        repeat (2) @(negedge HCLK);
        vectors++;
        if (cmd_ready !== 1'b1 || rsp_valid !== 1'b0 || rsp_data !== '0 || rsp_error !== 1'b0 ||
            HTRANS !== 2'b00 || HADDR !== '0 || HWRITE !== 1'b0 || HWDATA !== '0) begin
            miscompares++;
            $display("FAIL reset_values got rdy=%b v=%b d=%h e=%b tr=%b a=%h w=%b wd=%h want 1 0 0 0 00 0 0 0",
                     cmd_ready, rsp_valid, rsp_data, rsp_error, HTRANS, HADDR, HWRITE, HWDATA);
        end
        vectors++;
        if (HSIZE !== 3'b010 || HBURST !== 3'b000 || HPROT !== 4'b0011) begin
            miscompares++;
            $display("FAIL const_ctrl got size=%b burst=%b prot=%b want 010 000 0011", HSIZE, HBURST, HPROT);
        end
        HRESETn = 1'b1;
        @(negedge HCLK);
        vectors++;
        if (cmd_ready !== 1'b1 || HTRANS !== 2'b00) begin
            miscompares++; $display("FAIL post_reset got rdy=%b tr=%b want 1 00", cmd_ready, HTRANS);
        end
    endtask

    task automatic test_key_load;
        start_cmd(2'b00, 128'h000102030405060708090A0B0C0D0E0F, 0, 1, -1);
        finish_cmd("key_load", 0, 0);
    endtask

    task automatic test_encrypt_poll3;
        start_cmd(2'b01, {4{$urandom()}}, 0, 3, -1);
        cfg_res[0] = 32'hAAAA0001; cfg_res[1] = 32'hAAAA0002;
        cfg_res[2] = 32'hAAAA0003; cfg_res[3] = 32'hAAAA0004;
        exp_data = 128'hAAAA0001_AAAA0002_AAAA0003_AAAA0004;
        finish_cmd("encrypt_poll3", 1, 0);
    endtask

    task automatic test_decrypt_waits;
        start_cmd(2'b10, {$urandom(), $urandom(), $urandom(), $urandom()}, 2, 1, -1);
        finish_cmd("decrypt_waits", 0, 0);
    endtask

    task automatic test_bus_error;
        start_cmd(2'b01, {$urandom(), $urandom(), $urandom(), $urandom()}, 0, 1, 1);
        finish_cmd("bus_error", 0, 0);
    endtask

    task automatic test_timeout;
        start_cmd(2'b01, {$urandom(), $urandom(), $urandom(), $urandom()}, 0, 0, -1);
        finish_cmd("poll_timeout", 5, 1);
    endtask

    task automatic test_reserved;
        start_cmd(2'b11, {$urandom(), $urandom(), $urandom(), $urandom()}, 0, 1, -1);
        finish_cmd("reserved_op", 2, 1);
    endtask

    task automatic test_random;
        for (int i = 0; i < 24; i++) begin
            logic [1:0] op;
            int         err;
            op  = 2'($urandom_range(0, 3));
            err = ($urandom_range(0, 4) == 0) ? int'($urandom_range(0, 12)) : -1;
            start_cmd(op, {$urandom(), $urandom(), $urandom(), $urandom()},
                      int'($urandom_range(0, 2)), int'($urandom_range(0, PMAX)), err);
            finish_cmd("random", int'($urandom_range(0, 3)), 1'($urandom_range(0, 1)));
        end
    endtask

    task automatic test_reset_mid;
        bit found;
        found = 0;
        start_cmd(2'b01, {$urandom(), $urandom(), $urandom(), $urandom()}, 0, 1, -1);
        for (int k = 0; k < 200; k++) begin
            @(posedge HCLK); #1;
            if (HTRANS === 2'b00 && HADDR === A_RES && HWRITE === 1'b0) begin found = 1; break; end
        end
        vectors++;
        if (!found) begin
            miscompares++; $display("FAIL reset_mid reached_rd_d got 0 want 1");
        end
        #2 HRESETn = 1'b0;
        #1;
        vectors++;
        if (HTRANS !== 2'b00 || cmd_ready !== 1'b1 || rsp_valid !== 1'b0 || HADDR !== '0) begin
            miscompares++;
            $display("FAIL reset_mid async got tr=%b rdy=%b v=%b a=%h want 00 1 0 0",
                     HTRANS, cmd_ready, rsp_valid, HADDR);
        end
        repeat (2) @(negedge HCLK);
        HRESETn = 1'b1;
        @(posedge HCLK); #1;
        vectors++;
        if (cmd_ready !== 1'b1 || rsp_valid !== 1'b0 || HTRANS !== 2'b00) begin
            miscompares++;
            $display("FAIL reset_mid release got rdy=%b v=%b tr=%b want 1 0 00", cmd_ready, rsp_valid, HTRANS);
        end
        start_cmd(2'b01, {$urandom(), $urandom(), $urandom(), $urandom()}, 0, 1, -1);
        finish_cmd("after_reset", 0, 0);
    endtask

    initial begin
        test_reset;
        test_key_load;
        test_encrypt_poll3;
        test_decrypt_waits;
        test_bus_error;
        test_timeout;
        test_reserved;
        test_random;
        test_reset_mid;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog simulation did not complete");
        $fatal(1);
    end
endmodule

// File: doc/aes_ahb_master.md
Name: aes_ahb_master

Overview:
AHB-Lite initiator that drives the AES accelerator's AHB slave port from the system side. It accepts one 128-bit command per handshake: key load, encrypt or decrypt. It performs the single-transfer write/poll/read bus sequence and returns the 128-bit result, or an error, on a response handshake. It is used as the bus driver for on-chip clients and as the transaction engine of the system-level testbench.

Parameters:
DATA_ADDR, 32'h0000_0000, address of the input-data word register (all four words written here, MSW first)
CTRL_ADDR, 32'h0000_0004, control register; write value 1=key load, 2=encrypt, 4=decrypt
STATUS_ADDR, 32'h0000_0008, status register, polled after encrypt/decrypt
RESULT_ADDR, 32'h0000_000C, result word register (all four words read here, MSW first)
RDY_BIT, 0, status bit index meaning "result available"
POLL_MAX, 255, maximum status reads before timeout

Ports:
HCLK  in  1  system clock; all logic on rising edge
HRESETn  in  1  asynchronous active-low reset
cmd_valid  in  1  command present
cmd_op  in  2  00=key load, 01=encrypt, 10=decrypt, 11=reserved (treated as error)
cmd_data  in  128  key or data block
cmd_ready  out  1  high only in IDLE; command accepted when cmd_valid&cmd_ready
rsp_valid  out  1  response present; held until rsp_ready
rsp_ready  in  1  response consumed
rsp_data  out  128  result block; 0 for key load or error
rsp_error  out  1  bus error, timeout or reserved op
HADDR  out  32  AHB address
HWRITE  out  1  AHB direction
HTRANS  out  2  IDLE=00 or NONSEQ=10 only
HSIZE  out  3  constant 3'b010 (word)
HBURST  out  3  constant 3'b000 (SINGLE)
HPROT  out  4  constant 4'b0011
HWDATA  out  32  write data, valid in data phase
HRDATA  in  32  read data
HREADY  in  1  transfer complete / slave ready
HRESP  in  2  00=OKAY, 01=ERROR

Behaviour:
- Reset values: cmd_ready=1 (IDLE), rsp_valid=0, rsp_data=0, rsp_error=0, HTRANS=IDLE, HADDR=0, HWRITE=0, HWDATA=0, word counter=0, poll counter=0.
- Non-pipelined: each transfer is one address-phase state (HTRANS=NONSEQ) followed by one data-phase state (HTRANS=IDLE, address/HWRITE held).
- Address phase advances only when HREADY=1. Data phase stays until HREADY=1.
- HWDATA is registered on entry to the write data phase and held until completion.
- States:
  - IDLE: on accept, latch op and data, clear counters -> WR_A. A reserved op goes directly to RESP with rsp_error=1.
  - WR_A/WR_D: 4 writes to DATA_ADDR, word k = cmd_data[127-32k -: 32]. After word 3 completes -> CT_A. For key load, the key is sent through the same path.
  - CT_A/CT_D: write the op code to CTRL_ADDR. Key load -> RESP. Encrypt/decrypt -> PL_A.
  - PL_A/PL_D: read STATUS_ADDR.
    - HRDATA[RDY_BIT]=1 at completion -> RD_A.
    - Otherwise increment poll count. Count == POLL_MAX -> RESP with rsp_error=1. Else -> PL_A.
  - RD_A/RD_D: 4 reads of RESULT_ADDR. Word k is captured into rsp_data[127-32k -: 32] when HREADY=1. After word 3 -> RESP.
  - RESP: rsp_valid=1 with stable data and error; on rsp_ready -> IDLE.
- Error handling: HRESP=01 in any data-phase cycle, including the first ERROR cycle with HREADY=0, aborts the sequence. No further transfers; HTRANS stays IDLE. -> RESP with rsp_error=1, rsp_data=0.
- Zero-wait encrypt/decrypt, ready on first poll: accept at cycle T0, rsp_valid rises at T21. Each wait state adds one cycle.
- A new command is never accepted while RESP is pending.
- Asynchronous reset mid-sequence: HTRANS goes IDLE immediately, state returns to IDLE, and the pending response is discarded.

Test Plan:
- Zero-wait slave, key load, cmd_data=128'h000102...0F -> writes 32'h00010203, 32'h04050607, 32'h08090A0B, 32'h0C0D0E0F to DATA_ADDR, then 1 to CTRL_ADDR. rsp_valid at T11 with rsp_data=0, rsp_error=0.
- Encrypt, status ready on 3rd poll, result words 32'hAAAA0001..32'hAAAA0004 -> CTRL write value 2, exactly 3 STATUS reads, rsp_data=128'hAAAA0001_AAAA0002_AAAA0003_AAAA0004, rsp_valid at T25.
- Slave inserts 2 wait states on every data phase during decrypt -> HWDATA and HADDR stable while HREADY=0, CTRL write value 4, result correct, latency T21+2*(number of transfers).
- HRESP=ERROR on the second data write -> no CTRL write issued, HTRANS=IDLE thereafter, rsp_error=1, rsp_data=0.
- Status never ready, POLL_MAX=4 -> exactly 4 STATUS reads, then rsp_error=1. rsp_ready held low 5 cycles -> rsp_valid stays high and a concurrent cmd_valid is not accepted (cmd_ready=0).
- HRESETn pulsed low during RD_D -> HTRANS=00 same cycle, cmd_ready=1 after release, rsp_valid=0. A following encrypt completes normally.
